ddr_sim_rd_burst: RTL and testbench

Burst read engine that sits directly downstream of the simulation RAM in the DDR simulation model. It accepts a read command (start address, beat count) and drives the RAM read address one beat per cycle. It absorbs the RAM's fixed one-cycle read latency and streams the returned words out on a valid/ready interface with a last flag. Downstream backpressure is handled by a small credit-controlled FIFO, so no beat is ever lost or duplicated.

---
 rtl/ddr_sim_pkg.sv | 14 +
 rtl/sim_stream_fifo.sv | 66 ++++++
 rtl/ddr_sim_rd_burst.sv | 121 ++++++++++++
 tb/tb_ddr_sim_rd_burst.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_sim_pkg.sv
// Shared definitions for the DDR simulation model read path.
// Holds the FIFO depth, credit counter width and read-engine state encoding.
package ddr_sim_pkg;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned CREDIT_W   = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StDrain = 2'd2
    } rd_state_e;

endpackage

// File: rtl/sim_stream_fifo.sv
// Small synchronous FIFO with push/pop, empty/full and asynchronous active-low reset.
// Storage is cleared on reset so the head reads zero while empty.
module sim_stream_fifo #(
    parameter int unsigned Width = 9,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AddrW:0]   count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AddrW + 1)'(Depth));
    assign pop_data = mem_q[rd_ptr_q];
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d = (wr_ptr_q == AddrW'(Depth - 1)) ? '0 : wr_ptr_q + AddrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == AddrW'(Depth - 1)) ? '0 : rd_ptr_q + AddrW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AddrW + 1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (AddrW + 1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ddr_sim_rd_burst.sv
// Burst read engine: issues one RAM address per cycle, absorbs the one-cycle RAM latency
// and streams beats out through a credit-controlled FIFO with a last flag.
module ddr_sim_rd_burst
    import ddr_sim_pkg::*;
#(
    parameter int unsigned DATA_R  = 8,
    parameter int unsigned DEPTH_R = 8,
    parameter int unsigned LEN_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [DEPTH_R-1:0] cmd_addr,
    input  logic [LEN_W-1:0]   cmd_len,
    output logic [DEPTH_R-1:0] ram_raddr,
    input  logic [DATA_R-1:0]  ram_rdata,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [DATA_R-1:0]  m_data,
    output logic               m_last,
    output logic               busy
);
    rd_state_e             state_q, state_d;
    logic [DEPTH_R-1:0]    addr_cnt_q, addr_cnt_d;
    logic [LEN_W-1:0]      beat_rem_q, beat_rem_d;
    logic [DEPTH_R-1:0]    raddr_q, raddr_d;
    logic                  iss_q, iss_d;
    logic                  iss_last_q, iss_last_d;
    logic [CREDIT_W-1:0]   reserved_q, reserved_d;
    logic                  issue;
    logic                  pop;
    logic                  fifo_empty, fifo_full;

    assign m_valid = !fifo_empty;
    assign pop     = m_valid && m_ready;

    // Credits count beats issued but not yet popped, so the FIFO can never overflow.
    always_comb begin
        state_d    = state_q;
        addr_cnt_d = addr_cnt_q;
        beat_rem_d = beat_rem_q;
        raddr_d    = raddr_q;
        reserved_d = reserved_q;
        issue      = 1'b0;
        cmd_ready  = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_cnt_d = cmd_addr;
                    beat_rem_d = cmd_len;
                    state_d    = StRead;
                end
            end
            StRead: begin
                if (reserved_q < CREDIT_W'(FIFO_DEPTH)) begin
                    issue      = 1'b1;
                    raddr_d    = addr_cnt_q;
                    addr_cnt_d = addr_cnt_q + DEPTH_R'(1);
                    beat_rem_d = beat_rem_q - LEN_W'(1);
                    if (beat_rem_q == '0) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && m_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (issue && !pop) begin
            reserved_d = reserved_q + CREDIT_W'(1);
        end else if (pop && !issue) begin
            reserved_d = reserved_q - CREDIT_W'(1);
        end
        iss_d      = issue;
        iss_last_d = issue && (beat_rem_q == '0);
    end

    // The issuing address goes out combinationally so the RAM samples it at the next edge.
    assign ram_raddr = issue ? addr_cnt_q : raddr_q;
    assign busy      = (state_q != StIdle);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_cnt_q <= '0;
            beat_rem_q <= '0;
            raddr_q    <= '0;
            iss_q      <= 1'b0;
            iss_last_q <= 1'b0;
            reserved_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            beat_rem_q <= beat_rem_d;
            raddr_q    <= raddr_d;
            iss_q      <= iss_d;
            iss_last_q <= iss_last_d;
            reserved_q <= reserved_d;
        end
    end

    sim_stream_fifo #(
        .Width (DATA_R + 1),
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (iss_q && !fifo_full),
        .push_data ({iss_last_q, ram_rdata}),
        .pop       (pop),
        .pop_data  ({m_last, m_data}),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_ddr_sim_rd_burst.sv
// Scoreboard bench for ddr_sim_rd_burst: stimulus queues expected beats, a negedge monitor
// pops and compares every transferred beat. RAM model holds mem[i]=i with one-cycle latency.
module tb_ddr_sim_rd_burst;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_len;
    logic [7:0] ram_raddr;
    logic [7:0] ram_rdata;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       busy;

    logic [7:0] mem [256];
    logic [8:0] exp_q [$];
    int         errors = 0;
    int         checks = 0;
    int         pop_cnt = 0;
    logic       stall_q = 1'b0;
    logic [8:0] stall_beat = '0;
    logic [7:0] diff;
    logic [8:0] exp_beat;
    logic [31:0] pat = 32'hB3A5_6C9D;

    ddr_sim_rd_burst #(
        .DATA_R  (8),
        .DEPTH_R (8),
        .LEN_W   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_rdata <= mem[ram_raddr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [7:0] a, input int len);
        for (int i = 0; i <= len; i++) begin
            exp_q.push_back({(i == len), 8'(a + 8'(i))});
        end
    endtask

    // Called #1 after an edge; returns #1 after the accepting edge.
    task automatic send_cmd(input logic [7:0] a, input logic [7:0] len, input bit hold);
        int g;
        cmd_addr  = a;
        cmd_len   = len;
        cmd_valid = 1'b1;
        g = 0;
        while (!cmd_ready && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        check("cmd_accept", {31'd0, cmd_ready}, 1);
        @(posedge clk); #1;
        if (!hold) cmd_valid = 1'b0;
        else cmd_addr = 8'h99;
    endtask

    task automatic wait_idle(input bit toggle, input string name);
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            @(posedge clk); #1;
            if (toggle) m_ready = pat[i % 32];
        end
        check(name, {31'd0, busy}, 0);
        m_ready = 1'b1;
    endtask

    // Monitor: scoreboard pop, stall stability and credit window.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_valid", {31'd0, m_valid}, 1);
                check("stall_beat", {23'd0, m_last, m_data}, {23'd0, stall_beat});
            end
            if (busy && exp_q.size() != 0) begin
                diff = ram_raddr - exp_q[0][7:0];
                check("credit_window", {31'd0, (diff < 8'd4)}, 1);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected none", {m_last, m_data});
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("beat", {23'd0, m_last, m_data}, {23'd0, exp_beat});
                    pop_cnt++;
                end
            end
            stall_q    = m_valid && !m_ready;
            stall_beat = {m_last, m_data};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int g;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        m_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_valid", {31'd0, m_valid}, 0);
        check("rst_m_last", {31'd0, m_last}, 0);
        check("rst_m_data", {24'd0, m_data}, 0);
        check("rst_raddr", {24'd0, ram_raddr}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 1);

        // Basic burst: latency, throughput, turnaround.
        push_exp(8'h10, 3);
        send_cmd(8'h10, 8'd3, 1'b0);
        check("lat_e0", {31'd0, m_valid}, 0);
        check("issue_addr", {24'd0, ram_raddr}, 32'h10);
        @(posedge clk); #1;
        check("lat_e1", {31'd0, m_valid}, 0);
        @(posedge clk); #1;
        check("lat_e2", {31'd0, m_valid}, 1);
        check("first_data", {24'd0, m_data}, 32'h10);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); #1;
            check("stream_valid", {31'd0, m_valid}, 1);
            check("stream_data", {24'd0, m_data}, 32'h10 + i);
        end
        check("stream_last", {31'd0, m_last}, 1);
        @(posedge clk); #1;
        check("turn_busy", {31'd0, busy}, 0);
        check("turn_cmd_ready", {31'd0, cmd_ready}, 1);
        check("basic_drained", exp_q.size(), 0);

        // Address wrap.
        push_exp(8'hFE, 3);
        send_cmd(8'hFE, 8'd3, 1'b0);
        wait_idle(1'b0, "wrap_idle");
        check("wrap_drained", exp_q.size(), 0);

        // Pseudo-random backpressure.
        push_exp(8'h00, 15);
        send_cmd(8'h00, 8'd15, 1'b0);
        wait_idle(1'b1, "bp_idle");
        check("bp_drained", exp_q.size(), 0);

        // Long stall right after accept.
        @(posedge clk); #1;
        m_ready = 1'b0;
        push_exp(8'h00, 7);
        send_cmd(8'h00, 8'd7, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("stall_issues", {24'd0, ram_raddr}, 3);
        check("stall_valid_hi", {31'd0, m_valid}, 1);
        check("stall_head", {24'd0, m_data}, 0);
        m_ready = 1'b1;
        wait_idle(1'b0, "stall_idle");
        check("stall_drained", exp_q.size(), 0);

        // Single beat with cmd_valid held through the burst.
        @(posedge clk); #1;
        push_exp(8'h42, 0);
        send_cmd(8'h42, 8'd0, 1'b1);
        g = 0;
        while (!(m_valid && m_ready) && g < 20) begin
            check("hold_no_accept", {31'd0, cmd_ready}, 0);
            @(posedge clk); #1;
            g++;
        end
        check("single_valid", {31'd0, m_valid}, 1);
        @(posedge clk); #1;
        check("single_busy", {31'd0, busy}, 0);
        check("single_cmd_ready", {31'd0, cmd_ready}, 1);
        cmd_valid = 1'b0;
        check("single_drained", exp_q.size(), 0);

        // Reset in the middle of a long burst.
        @(posedge clk); #1;
        base = pop_cnt;
        push_exp(8'h20, 31);
        send_cmd(8'h20, 8'd31, 1'b0);
        g = 0;
        while (pop_cnt < base + 5 && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        check("pre_rst_pops", {31'd0, (pop_cnt >= base + 5)}, 1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_m_valid", {31'd0, m_valid}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        push_exp(8'h80, 1);
        send_cmd(8'h80, 8'd1, 1'b0);
        wait_idle(1'b0, "post_rst_idle");
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_drained", exp_q.size(), 0);
        check("post_rst_quiet", {31'd0, m_valid}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
